nes_vga_scaler: RTL and testbench
=================================

# nes_vga_scaler

Parametrised NES-to-VGA output stage: generates VGA sync timing, prefetches each source row from frame VRAM into a ping-pong line buffer, and integer-scales the SRC_W×SRC_H picture into a centred window on the VGA raster. Pixels outside the window show a border colour; everything is converted through the NES 64-entry palette to 12-bit RGB. It sits between the PPU-written frame VRAM and the board VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 porch/sync widths
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33
- SRC_W, 256, source pixels per row; SRC_H, 240, source rows
- SCALE, 2, integer scale factor (1..4), applied both axes
- H_OFFSET, 64, first picture column; requires H_OFFSET+SRC_W*SCALE ≤ H_ACTIVE, SRC_H*SCALE ≤ V_ACTIVE
- BORDER_COLOR, 6'h0F, palette index shown outside the picture window
- PCK  in  1  pixel clock
- RST  in  1  asynchronous reset, active-high
- vram_addr  out  16  source pixel address = row*SRC_W + col
- vram_rd  out  1  read strobe; one address per cycle
- vram_data  in  6  palette index, valid exactly one cycle after vram_rd
- vga_r, vga_g, vga_b  out  4 each  colour, 0 during blanking
- vga_hs, vga_vs  out  1  sync, active-low
- frame_start  out  1  one-cycle pulse when hcnt=0, vcnt=0 leaves the pipeline

## Operation
- hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1 (H_TOTAL=800, V_TOTAL=525 by default); vcnt advances when hcnt wraps.
- Active: hcnt<H_ACTIVE && vcnt<V_ACTIVE. Window: H_OFFSET ≤ hcnt < H_OFFSET+SRC_W*SCALE && vcnt < SRC_H*SCALE. Active outside window → BORDER_COLOR; blanking → RGB 0.
- Source col = (hcnt-H_OFFSET)/SCALE, row = vcnt/SCALE; divide by counters (sub-pixel and sub-line counters), no divider.
- Line buffer: two banks × SRC_W × 6 bits; row r displayed from bank r[0].
- Fill FSM: IDLE → FETCH (SRC_W cycles, vram_rd=1, col 0..SRC_W-1) → DRAIN (1 cycle, last write) → IDLE.
- Fill trigger at hcnt=0 of: first output line of row r (fetch row r+1 into bank (r+1)[0], only if r+1<SRC_H); vcnt=V_TOTAL-1 (fetch row 0 into bank 0).
- Per-bank valid flag set at DRAIN; cleared on reset and when bank starts a new fetch. Window pixels from an invalid bank show index 6'h0F (black).
- Trigger while FSM not IDLE is impossible for legal parameters (SRC_W+2 < H_TOTAL); FSM ignores it.
- Palette: 64-entry constant ROM, index → {r,g,b} 12 bits.

## Timing
- Output pipeline 2 cycles: stage 1 reads line buffer/selects index, stage 2 palette lookup and registers RGB. hs, vs, blank and frame_start delayed identically, so colour and sync stay aligned.
- vga_hs low for hcnt in [H_ACTIVE+H_FP, +H_SYNC); vga_vs low for vcnt in [V_ACTIVE+V_FP, +V_SYNC), both before the 2-cycle delay.
- Buffer write of column c occurs one cycle after its vram_rd.
- Reset values: counters 0, FSM IDLE, vram_rd 0, vram_addr 0, RGB 0, vga_hs 1, vga_vs 1, frame_start 0, valid flags 0. Reset mid-fetch aborts; first frame after reset shows black picture window (row 0 not yet fetched), border correct.

## Configuration
- NES_VGA_SCANLINE_EN defined: on window lines where the sub-line counter equals SCALE-1 (and SCALE>1), each RGB channel is halved (shift right 1). Undefined: all scaled lines identical. Border and blanking unaffected either way.

## Structure
- Package nes_vga_pkg: default timing constants, palette ROM (64×12 constant array + lookup function), fill FSM state enum.
- One sub-module nes_vga_line_buffer: two-bank simple-dual-port RAM, synchronous read, one write port.

## Test plan
- Reset then run 2 frames → hs period 800, low 96 cycles; vs period 420000 cycles, low 1600; frame_start once per frame.
- VRAM model returning addr[5:0]; at vcnt=0, hcnt=64..575 second frame → indices 0,0,1,1,…,63,63 repeat (after 2-cycle delay).
- Check fetch: at vcnt=2, hcnt=0 → vram_rd high 256 cycles, addresses 512..767 (row 2 into bank 0).
- hcnt 0..63 and 576..639 of active lines → palette[0x0F]; hcnt≥640 or vcnt≥480 → RGB 0.
- Assert RST at vcnt=100 hcnt=10 (mid-fetch) → all outputs at reset values immediately; next frame window black, following frame correct.
- NES_VGA_SCANLINE_EN, index 0x30 (white, 12'hFFF) → even lines 4'hF per channel, odd lines 4'h7.

Source files
------------

// File: rtl/nes_vga_pkg.sv
// nes_vga_pkg: default 640x480@60 timing, NES palette ROM (index -> 12-bit RGB)
// and the line-buffer fill FSM state type.
package nes_vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SRC_W    = 256;
    localparam int DEF_SRC_H    = 240;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fill_t;

    localparam logic [11:0] PALETTE [64] = '{
        12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
        12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
        12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
        12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
        12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
        12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
        12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
        12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
    };

    function automatic logic [11:0] pal(input logic [5:0] idx);
        return PALETTE[idx];
    endfunction
endpackage

// File: rtl/nes_vga_line_buffer.sv
// nes_vga_line_buffer: two-bank line RAM, one write port, registered read port.
module nes_vga_line_buffer #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [5:0]    rd_data
);
    logic [5:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end
endmodule

// File: rtl/nes_vga_scaler.sv
// nes_vga_scaler: VGA timing, row prefetch into ping-pong buffer, integer upscale and palette.
// Optional NES_VGA_SCANLINE_EN halves RGB on the last sub-line of each scaled source row.
module nes_vga_scaler
    import nes_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SRC_W    = DEF_SRC_W,
    parameter int SRC_H    = DEF_SRC_H,
    parameter int SCALE    = 2,
    parameter int H_OFFSET = 64,
    parameter logic [5:0] BORDER_COLOR = 6'h0F
) (
    input  logic        PCK,
    input  logic        RST,
    output logic [15:0] vram_addr,
    output logic        vram_rd,
    input  logic [5:0]  vram_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int CW = $clog2(SRC_W);
    localparam int SW = SCALE > 1 ? $clog2(SCALE) : 1;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt, row, frow;
    logic [CW-1:0] col, fcol, wr_col;
    logic [SW-1:0] sx, sy;
    logic [1:0] valid;
    logic [5:0] rd_data, idx;
    logic [11:0] rgb;
    logic h_end, v_end, in_hwin, in_vwin, trigger, nbank, fbank, wr_en, wr_bank;
    logic s1_act, s1_win, s1_valid, s1_hs, s1_vs, s1_fs;
    fill_t state, state_nx;

    assign h_end   = hcnt == HW'(H_TOTAL - 1);
    assign v_end   = vcnt == VW'(V_TOTAL - 1);
    assign in_hwin = hcnt >= HW'(H_OFFSET) && hcnt < HW'(H_OFFSET + SRC_W * SCALE);
    assign in_vwin = vcnt < VW'(SRC_H * SCALE);
    assign trigger = hcnt == '0 && (v_end || (in_vwin && sy == '0 && int'(row) + 1 < SRC_H));
    assign nbank   = v_end ? 1'b0 : ~row[0];

    // col/sx and row/sy always describe the current hcnt/vcnt, so no divider is needed
    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            hcnt <= '0;
            vcnt <= '0;
            col  <= '0;
            sx   <= '0;
            row  <= '0;
            sy   <= '0;
        end else begin
            hcnt <= h_end ? '0 : hcnt + 1'b1;
            sx   <= (!in_hwin || sx == SW'(SCALE - 1)) ? '0 : sx + 1'b1;
            col  <= !in_hwin ? '0 : (sx == SW'(SCALE - 1) ? col + 1'b1 : col);
            if (h_end) begin
                vcnt <= v_end ? '0 : vcnt + 1'b1;
                sy   <= (v_end || sy == SW'(SCALE - 1)) ? '0 : sy + 1'b1;
                row  <= v_end ? '0 : (sy == SW'(SCALE - 1) ? row + 1'b1 : row);
            end
        end
    end

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE && trigger) ? FETCH :
                   (state == FETCH && fcol == CW'(SRC_W - 1)) ? DRAIN :
                   (state == DRAIN) ? IDLE : state;
    end

    always_comb begin
        vram_rd   = state == FETCH;
        vram_addr = 16'(int'(frow) * SRC_W + int'(fcol));
    end

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            fcol    <= '0;
            frow    <= '0;
            fbank   <= 1'b0;
            valid   <= '0;
            wr_en   <= 1'b0;
            wr_col  <= '0;
            wr_bank <= 1'b0;
        end else begin
            wr_en   <= vram_rd;
            wr_col  <= fcol;
            wr_bank <= fbank;
            if (state == IDLE && trigger) begin
                fcol         <= '0;
                frow         <= v_end ? '0 : row + 1'b1;
                fbank        <= nbank;
                valid[nbank] <= 1'b0;
            end else if (state == FETCH) begin
                fcol <= fcol == CW'(SRC_W - 1) ? '0 : fcol + 1'b1;
            end
            if (state == DRAIN) valid[fbank] <= 1'b1;
        end
    end

    nes_vga_line_buffer #(.DEPTH(SRC_W)) u_buf (
        .clk     (PCK),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_col),
        .wr_data (vram_data),
        .rd_bank (row[0]),
        .rd_addr (col),
        .rd_data (rd_data)
    );

`ifdef NES_VGA_SCANLINE_EN
    logic s1_scan;
    always_ff @(posedge PCK or posedge RST) begin
        if (RST) s1_scan <= 1'b0;
        else s1_scan <= SCALE > 1 && sy == SW'(SCALE - 1);
    end
`endif

    // stage 1 travels alongside the synchronous buffer read
    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            s1_act   <= 1'b0;
            s1_win   <= 1'b0;
            s1_valid <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_fs    <= 1'b0;
        end else begin
            s1_act   <= hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
            s1_win   <= in_hwin && in_vwin;
            s1_valid <= valid[row[0]];
            s1_hs    <= !(hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
            s1_vs    <= !(vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
            s1_fs    <= hcnt == '0 && vcnt == '0;
        end
    end

    always_comb begin
        idx = !s1_win ? BORDER_COLOR : (s1_valid ? rd_data : 6'h0F);
        rgb = s1_act ? pal(idx) : 12'h000;
`ifdef NES_VGA_SCANLINE_EN
        rgb = (s1_act && s1_win && s1_scan) ? {1'b0, rgb[11:9], 1'b0, rgb[7:5], 1'b0, rgb[3:1]} : rgb;
`endif
    end

    always_ff @(posedge PCK or posedge RST) begin
        if (RST) begin
            {vga_r, vga_g, vga_b} <= 12'h000;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= rgb;
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            frame_start <= s1_fs;
        end
    end
endmodule

// File: tb/tb_nes_vga_scaler.sv
// tb_nes_vga_scaler: directed checks on a shrunken raster (50x36 total, 16x12 source, scale 2).
// Output seen at cycle c after reset release belongs to raster position c-2.
module tb_nes_vga_scaler;
    localparam int HT = 50;
    localparam int FR = 50 * 36;

    logic        PCK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] vram_addr;
    logic        vram_rd;
    logic [5:0]  vram_data = '0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int hs_low = 0, vs_low = 0, fs_cnt = 0, hs_fall = 0, resets = 0;
    logic prev_hs = 1'b1;

    typedef struct {
        int h;
        int v;
        logic [11:0] rgb;
        logic hs;
        logic vs;
    } vec_t;
    vec_t tbl [21];

    nes_vga_scaler #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SRC_W(16), .SRC_H(12), .SCALE(2), .H_OFFSET(4), .BORDER_COLOR(6'h21)
    ) dut (
        .PCK(PCK), .RST(RST), .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .frame_start(frame_start)
    );

    always #5 PCK = ~PCK;

    always @(posedge PCK) begin
        vram_data <= vram_addr[5:0];
        cyc <= RST ? 0 : cyc + 1;
    end

    always @(negedge PCK) begin
        if (resets == 0 && !RST && cyc >= FR + 2 && cyc < 2 * FR + 2) begin
            if (!vga_hs) hs_low++;
            if (!vga_vs) vs_low++;
            if (frame_start) fs_cnt++;
            if (prev_hs && !vga_hs) hs_fall++;
        end
        prev_hs <= vga_hs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge PCK);
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, " rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
        chk({tag, " hs"}, vga_hs, 1'b1);
        chk({tag, " vs"}, vga_vs, 1'b1);
        chk({tag, " fs"}, frame_start, 1'b0);
        chk({tag, " rd"}, vram_rd, 1'b0);
        chk({tag, " addr"}, vram_addr, 16'd0);
    endtask

    task automatic first_frame(input string tag);
        at(1);
        chk({tag, " fetch row1 rd"}, vram_rd, 1'b1);
        chk({tag, " fetch row1 addr"}, vram_addr, 16'd16);
        at(4);
        chk({tag, " f0 border"}, {vga_r, vga_g, vga_b}, 12'h3BF);
        at(6);
        chk({tag, " f0 row0 black a"}, {vga_r, vga_g, vga_b}, 12'h000);
        at(HT + 12);
        chk({tag, " f0 row0 black b"}, {vga_r, vga_g, vga_b}, 12'h000);
    endtask

    initial begin
        logic [11:0] exp;
        tbl[0]  = '{3, 0, 12'h3BF, 1'b1, 1'b1};
        tbl[1]  = '{4, 0, 12'h777, 1'b1, 1'b1};
        tbl[2]  = '{5, 0, 12'h777, 1'b1, 1'b1};
        tbl[3]  = '{6, 0, 12'h00F, 1'b1, 1'b1};
        tbl[4]  = '{36, 0, 12'h3BF, 1'b1, 1'b1};
        tbl[5]  = '{13, 1, 12'h908, 1'b1, 1'b1};
        tbl[6]  = '{10, 2, 12'h64F, 1'b1, 1'b1};
        tbl[7]  = '{39, 5, 12'h3BF, 1'b1, 1'b1};
        tbl[8]  = '{40, 5, 12'h000, 1'b1, 1'b1};
        tbl[9]  = '{43, 5, 12'h000, 1'b0, 1'b1};
        tbl[10] = '{46, 5, 12'h000, 1'b1, 1'b1};
        tbl[11] = '{20, 12, 12'hFB0, 1'b1, 1'b1};
        tbl[12] = '{4, 22, 12'hFFF, 1'b1, 1'b1};
        tbl[13] = '{4, 23, 12'hFFF, 1'b1, 1'b1};
        tbl[14] = '{30, 23, 12'hFDF, 1'b1, 1'b1};
        tbl[15] = '{10, 24, 12'h3BF, 1'b1, 1'b1};
        tbl[16] = '{10, 29, 12'h3BF, 1'b1, 1'b1};
        tbl[17] = '{10, 30, 12'h000, 1'b1, 1'b1};
        tbl[18] = '{10, 32, 12'h000, 1'b1, 1'b0};
        tbl[19] = '{45, 33, 12'h000, 1'b0, 1'b0};
        tbl[20] = '{10, 34, 12'h000, 1'b1, 1'b1};

        repeat (3) @(negedge PCK);
        rst_vals("reset");
        RST = 1'b0;
        first_frame("boot");

        at(FR + 2);
        chk("frame_start pulse", frame_start, 1'b1);
        at(FR + 3);
        chk("frame_start width", frame_start, 1'b0);

        for (int i = 0; i < 21; i++) begin
            exp = tbl[i].rgb;
`ifdef NES_VGA_SCANLINE_EN
            if (tbl[i].v < 24 && tbl[i].v % 2 == 1 && tbl[i].h >= 4 && tbl[i].h < 36)
                exp = {1'b0, exp[11:9], 1'b0, exp[7:5], 1'b0, exp[3:1]};
`endif
            at(FR + tbl[i].v * HT + tbl[i].h + 2);
            chk($sformatf("rgb h%0d v%0d", tbl[i].h, tbl[i].v), {vga_r, vga_g, vga_b}, exp);
            chk($sformatf("hs h%0d v%0d", tbl[i].h, tbl[i].v), vga_hs, tbl[i].hs);
            chk($sformatf("vs h%0d v%0d", tbl[i].h, tbl[i].v), vga_vs, tbl[i].vs);
        end

        at(2 * FR + 2);
        chk("hs low cycles/frame", hs_low, 144);
        chk("hs pulses/frame", hs_fall, 36);
        chk("vs low cycles/frame", vs_low, 100);
        chk("frame_start count", fs_cnt, 1);

        at(2 * FR + 2 * HT);
        chk("fetch row2 idle", vram_rd, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            at(2 * FR + 2 * HT + k);
            chk($sformatf("fetch row2 rd %0d", k), vram_rd, 1'b1);
            chk($sformatf("fetch row2 addr %0d", k), vram_addr, 16'(32 + k - 1));
        end
        at(2 * FR + 2 * HT + 17);
        chk("fetch row2 drain", vram_rd, 1'b0);

        at(2 * FR + 4 * HT + 10);
        chk("mid-fetch rd", vram_rd, 1'b1);
        chk("mid-fetch addr", vram_addr, 16'd57);
        resets++;
        RST = 1'b1;
        #1;
        rst_vals("mid reset");
        repeat (2) @(negedge PCK);
        RST = 1'b0;
        first_frame("after reset");

        at(FR + 6 + 2);
        chk("recovered v0 h6", {vga_r, vga_g, vga_b}, 12'h00F);
        at(FR + HT + 13 + 2);
`ifdef NES_VGA_SCANLINE_EN
        chk("recovered v1 h13", {vga_r, vga_g, vga_b}, 12'h404);
`else
        chk("recovered v1 h13", {vga_r, vga_g, vga_b}, 12'h908);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
